result_uart_logger: RTL

- Downstream consumer of the processor top's registered result_out[31:0] and flags_out[3:0].
- Detects every change in the {flags, result} pair and queues it as a 36-bit record in a small FIFO.
- Serialises each record as a 5-byte 8N1 UART frame, so a host can trace program execution on the board.
- Runs in the processor's CLOCK_50 domain. No CDC.

---
 rtl/logger_pkg.sv | 12 +
 rtl/result_fifo.sv | 50 +++++
 rtl/result_uart_logger.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/logger_pkg.sv
// Shared types for the result UART logger: TX FSM states and the queued record layout.
package logger_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int REC_W         = 36;
  localparam int BYTES_PER_REC = 5;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] result;
  } rec_t;
endpackage

// File: rtl/result_fifo.sv
// Synchronous record FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
module result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/result_uart_logger.sv
// Logs every change of the processor {flags, result} pair and sends it as a 5-byte 8N1 UART frame.
module result_uart_logger
  import logger_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic                          capture_en,
  input  logic [31:0]                   result_in,
  input  logic [3:0]                    flags_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output tx_state_t                     dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);

  rec_t              cur_rec, prev_q;
  logic              prev_valid_q, push_req, push_acc, pop;
  logic              fifo_full, fifo_empty;
  logic [REC_W-1:0]  fifo_dout;
  logic              overflow_q;

  tx_state_t         state_q;
  logic              tx_q, busy_q, busy_d, baud_end, frame_end;
  logic [BW-1:0]     baud_q;
  logic [2:0]        bit_idx_q, byte_idx_q;
  logic [39:0]       shift_q;
  logic [7:0]        cur_byte;
  logic [CW-1:0]     count_next;

  assign cur_rec  = '{flags: flags_in, result: result_in};
  assign push_req = capture_en && (!prev_valid_q || (cur_rec != prev_q));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (capture_en) begin
      prev_q       <= cur_rec;
      prev_valid_q <= 1'b1;
    end
  end

  result_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (cur_rec),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                              overflow_q <= 1'b0;
    else if (push_req && fifo_full && !pop)  overflow_q <= 1'b1;
  end

  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign push_acc  = push_req && (!fifo_full || pop);
  assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
  assign frame_end = (state_q == STOP) && baud_end && (byte_idx_q == 3'(BYTES_PER_REC - 1));
  assign cur_byte  = shift_q[39:32];

  // busy is registered from next-cycle state and count so it drops on the same edge the FSM returns to IDLE.
  assign count_next = fifo_count + CW'(push_acc) - CW'(pop);
  assign busy_d     = ((state_q == IDLE) ? pop : !frame_end) || (count_next != '0);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            baud_q     <= '0;
            byte_idx_q <= '0;
            shift_q    <= {4'h0, fifo_dout};
          end
        end
        START: begin
          if (baud_end) begin
            state_q   <= DATA;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (!frame_end) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              shift_q    <= {shift_q[31:0], 8'h00};
              state_q    <= START;
              tx_q       <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;
endmodule
